pipe_mul32: RTL and testbench



---
 rtl/pipe_mul32_pkg.sv | 16 +
 rtl/mul16x16_pp.sv | 39 +++
 rtl/pipe_mul32.sv | 73 +++++++
 tb/tb_pipe_mul32.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mul32_pkg.sv
// Shared widths, types and helpers for the pipelined 32x32 multiplier.
package pipe_mul32_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 2 * MUL_W;
  localparam int HALF_W = 16;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [MUL_W-1:0]  pp_t;

  // Widen a 32-bit partial product to the full product width, honouring its signedness.
  function automatic prod_t pp_extend(input pp_t pp, input logic sgn);
    return sgn ? {{MUL_W{pp[MUL_W-1]}}, pp} : {{MUL_W{1'b0}}, pp};
  endfunction

endpackage

// File: rtl/mul16x16_pp.sv
// Registered 16x16 partial-product unit; each operand half may be treated as signed (17x17 semantics).
module mul16x16_pp
  import pipe_mul32_pkg::*;
#(
  parameter bit SIGNED_A = 1'b0,
  parameter bit SIGNED_B = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ce_i,
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output pp_t               pp_o
);

  logic signed [MUL_W-1:0] a_x_p0;
  logic signed [MUL_W-1:0] b_x_p0;
  pp_t                     pp_d;
  pp_t                     pp_q;

  // The exact product always fits in 32 bits, so the low word of a 32-bit multiply is exact.
  always_comb begin
    a_x_p0 = SIGNED_A ? {{HALF_W{a_i[HALF_W-1]}}, a_i} : {{HALF_W{1'b0}}, a_i};
    b_x_p0 = SIGNED_B ? {{HALF_W{b_i[HALF_W-1]}}, b_i} : {{HALF_W{1'b0}}, b_i};
    pp_d   = a_x_p0 * b_x_p0;
  end

  // Stage 1 boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pp_q <= '0;
    end else if (ce_i) begin
      pp_q <= pp_d;
    end
  end

  assign pp_o = pp_q;

endmodule

// File: rtl/pipe_mul32.sv
// Fully pipelined 32x32 -> 64 multiplier with LATENCY register stages.
// Optional clock enable port CE when PIPE_MUL32_CE_EN is defined.
module pipe_mul32
  import pipe_mul32_pkg::*;
#(
  parameter int LATENCY = 6,
  parameter bit SIGNED  = 1'b0
) (
  input  logic              CLK,
  input  logic              rst,
`ifdef PIPE_MUL32_CE_EN
  input  logic              CE,
`endif
  input  logic [MUL_W-1:0]  A,
  input  logic [MUL_W-1:0]  B,
  output logic [PROD_W-1:0] P
);

  localparam int NQ = LATENCY - 1;

  if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
    $error("pipe_mul32: LATENCY must lie in 2..8");
  end

  logic ce;
`ifdef PIPE_MUL32_CE_EN
  assign ce = CE;
`else
  assign ce = 1'b1;
`endif

  pp_t pp_ll_p1, pp_lh_p1, pp_hl_p1, pp_hh_p1;

  // Stage 1 boundary: only high halves carry a sign in signed mode
  mul16x16_pp #(.SIGNED_A(1'b0), .SIGNED_B(1'b0)) u_pp_ll (
    .clk_i(CLK), .rst_i(rst), .ce_i(ce),
    .a_i(A[HALF_W-1:0]), .b_i(B[HALF_W-1:0]), .pp_o(pp_ll_p1)
  );
  mul16x16_pp #(.SIGNED_A(1'b0), .SIGNED_B(SIGNED)) u_pp_lh (
    .clk_i(CLK), .rst_i(rst), .ce_i(ce),
    .a_i(A[HALF_W-1:0]), .b_i(B[MUL_W-1:HALF_W]), .pp_o(pp_lh_p1)
  );
  mul16x16_pp #(.SIGNED_A(SIGNED), .SIGNED_B(1'b0)) u_pp_hl (
    .clk_i(CLK), .rst_i(rst), .ce_i(ce),
    .a_i(A[MUL_W-1:HALF_W]), .b_i(B[HALF_W-1:0]), .pp_o(pp_hl_p1)
  );
  mul16x16_pp #(.SIGNED_A(SIGNED), .SIGNED_B(SIGNED)) u_pp_hh (
    .clk_i(CLK), .rst_i(rst), .ce_i(ce),
    .a_i(A[MUL_W-1:HALF_W]), .b_i(B[MUL_W-1:HALF_W]), .pp_o(pp_hh_p1)
  );

  prod_t sum_p2_d;
  always_comb begin
    sum_p2_d = pp_extend(pp_ll_p1, 1'b0)
             + (pp_extend(pp_lh_p1, SIGNED) << HALF_W)
             + (pp_extend(pp_hl_p1, SIGNED) << HALF_W)
             + (pp_extend(pp_hh_p1, SIGNED) << MUL_W);
  end

  // Stage 2 boundary (sum), then pass-through stages up to LATENCY
  prod_t pipe_q [NQ];
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NQ; i++) pipe_q[i] <= '0;
    end else if (ce) begin
      pipe_q[0] <= sum_p2_d;
      for (int i = 1; i < NQ; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign P = pipe_q[NQ-1];

endmodule

// File: tb/tb_pipe_mul32.sv
// Self-checking bench for pipe_mul32: unsigned and signed instances against a product-queue model.
module tb_pipe_mul32;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic [63:0] p_u, p_s;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;

  logic [63:0] mq_u [LAT];
  logic [63:0] mq_s [LAT];

  logic [31:0] st_a [4] = '{32'h2, 32'h10000, 32'h12345678, 32'h0};
  logic [31:0] st_b [4] = '{32'h3, 32'h10000, 32'h9ABCDEF0, 32'hDEADBEEF};
  logic [63:0] st_p [4] = '{64'h6, 64'h1_0000_0000, 64'h0B00EA4E242D2080, 64'h0};

  always #5 clk = ~clk;

  pipe_mul32 #(.LATENCY(LAT), .SIGNED(1'b0)) dut_u (
    .CLK(clk), .rst(rst),
`ifdef PIPE_MUL32_CE_EN
    .CE(ce),
`endif
    .A(a), .B(b), .P(p_u)
  );

  pipe_mul32 #(.LATENCY(LAT), .SIGNED(1'b1)) dut_s (
    .CLK(clk), .rst(rst),
`ifdef PIPE_MUL32_CE_EN
    .CE(ce),
`endif
    .A(a), .B(b), .P(p_s)
  );

  function automatic logic [63:0] mul_model(input logic [31:0] x, input logic [31:0] y,
                                            input bit sgn);
    logic signed [63:0] sx, sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [63:0] eu, input logic [63:0] es);
    check({nm, "_u"}, p_u, eu);
    check({nm, "_s"}, p_s, es);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a queue of exact products, one entry per enabled edge, emptied by reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        mq_u[i] <= '0;
        mq_s[i] <= '0;
      end
    end else if (ce) begin
      for (int i = LAT - 1; i > 0; i--) begin
        mq_u[i] <= mq_u[i-1];
        mq_s[i] <= mq_s[i-1];
      end
      mq_u[0] <= mul_model(a, b, 1'b0);
      mq_s[0] <= mul_model(a, b, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_u", p_u, mq_u[LAT-1]);
      check("model_s", p_s, mq_s[LAT-1]);
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      tick();
      a = $urandom;
      b = $urandom;
      lit("rst_hold", 64'h0, 64'h0);
    end

    tick();
    rst = 1'b0;
    a = 32'd3;
    b = 32'd5;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      if (e < LAT) lit("fill_zero", 64'h0, 64'h0);
      else         lit("first_prod", 64'hF, 64'hF);
    end
    tick();
    lit("held_const", 64'hF, 64'hF);

    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      if (e == LAT - 1) lit("ext_early", 64'hF, 64'hF);
      if (e == LAT)     lit("ext_max", 64'hFFFF_FFFE_0000_0001, 64'h1);
    end

    for (int j = 1; j <= LAT + 3; j++) begin
      if (j <= 4) begin
        a = st_a[j-1];
        b = st_b[j-1];
      end else begin
        a = '0;
        b = '0;
      end
      tick();
      if (j >= LAT) check("stream_u", p_u, st_p[j-LAT]);
    end

    a = 32'hFFFF_FFFF;
    b = 32'h0000_0007;
    repeat (LAT) tick();
    lit("m1_x7", 64'h0000_0006_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9);

    a = 32'h8000_0000;
    b = 32'h8000_0000;
    repeat (LAT) tick();
    lit("min_sq", 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);

    for (int i = 0; i < 4; i++) begin
      a = 32'h0001_0003 + i;
      b = 32'h0002_0005 + i;
      tick();
    end
    #2 rst = 1'b1;
    #1 lit("rst_async_drop", 64'h0, 64'h0);
    a = '0;
    b = '0;
    tick();
    lit("rst_mid_1", 64'h0, 64'h0);
    tick();
    lit("rst_mid_2", 64'h0, 64'h0);
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      lit("post_rst_zero", 64'h0, 64'h0);
    end

    a = 32'd11;
    b = 32'd13;
    repeat (LAT) tick();
    lit("post_rst_prod", 64'h8F, 64'h8F);

`ifdef PIPE_MUL32_CE_EN
    a = 32'd7;
    b = 32'd9;
    tick();
    tick();
    ce = 1'b0;
    a = 32'hDEAD;
    b = 32'hBEEF;
    tick();
    lit("ce_hold_1", 64'h8F, 64'h8F);
    tick();
    tick();
    lit("ce_hold_3", 64'h8F, 64'h8F);
    a = 32'd7;
    b = 32'd9;
    ce = 1'b1;
    tick();
    tick();
    tick();
    lit("ce_late", 64'h8F, 64'h8F);
    tick();
    lit("ce_prod", 64'h3F, 64'h3F);
`endif

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
